// File: rtl/debug_tx_scheduler_pkg.sv
// Shared constants for the debug transmit path.
package debug_tx_scheduler_pkg;

    // Byte width of the debug UART.
    localparam int UART_BITS_DEF = 8;

endpackage

// File: rtl/debug_tx_scheduler_rr_arbiter.sv
// Round-robin selector: the first active request after last_served wins.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_served,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Walk the requesters starting one past the last one served and stop at the first request.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'((int'(last_served) + i) % N_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/debug_tx_scheduler.sv
// Arbitrates requester words and sends each one to a byte UART, LSB byte first.
module debug_tx_scheduler
    import debug_tx_scheduler_pkg::*;
#(
    parameter int UART_BITS = UART_BITS_DEF,
    parameter int WORD_BITS = 32,
    parameter int N_REQ     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [N_REQ*WORD_BITS-1:0] i_data,
    output logic [N_REQ-1:0]           o_grant,
    output logic                       o_tx_start,
    output logic [UART_BITS-1:0]       o_tx_data,
    input  logic                       i_tx_done,
    output logic                       o_word_done,
    output logic                       o_busy
);

    localparam int NBYTES = WORD_BITS / UART_BITS;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int IDX_W  = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e                               state_q, state_d;
    logic [CNT_W-1:0]                     byte_cnt_q, byte_cnt_d;
    logic [WORD_BITS-1:0]                 word_q, word_d;
    logic [IDX_W-1:0]                     last_q, last_d;
    logic [N_REQ-1:0]                     arb_grant;
    logic [IDX_W-1:0]                     arb_idx;
    logic [N_REQ-1:0][WORD_BITS-1:0]      data_arr;
    logic [NBYTES-1:0][UART_BITS-1:0]     word_bytes;

    assign data_arr   = i_data;
    assign word_bytes = word_q;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req         (i_req),
        .last_served (last_q),
        .grant       (arb_grant),
        .idx         (arb_idx)
    );

    // Next-state and pulse outputs; a word is captured only at grant so later data changes are harmless.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        last_d      = last_q;
        o_grant     = '0;
        o_tx_start  = 1'b0;
        o_word_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (|i_req) begin
                    o_grant    = arb_grant;
                    word_d     = data_arr[arb_idx];
                    last_d     = arb_idx;
                    byte_cnt_d = '0;
                    state_d    = START;
                end
            end
            START: begin
                o_tx_start = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                if (i_tx_done) begin
                    if (byte_cnt_q == CNT_W'(NBYTES - 1)) begin
                        state_d = DONE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                        state_d    = START;
                    end
                end
            end
            DONE: begin
                o_word_done = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Keep every pulse quiet while reset is asserted, even before the state flop clears.
        if (rst) begin
            o_grant     = '0;
            o_tx_start  = 1'b0;
            o_word_done = 1'b0;
        end
    end

    // The current byte is shown only while it is being sent, so it stays fixed from START through WAIT.
    always_comb begin
        o_tx_data = '0;
        if (!rst && (state_q == START || state_q == WAIT)) begin
            o_tx_data = word_bytes[byte_cnt_q];
        end
    end

    assign o_busy = !rst && (state_q != IDLE);

    // State registers; reset leaves requester 0 as the first to be served.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            word_q     <= '0;
            last_q     <= IDX_W'(N_REQ - 1);
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            last_q     <= last_d;
        end
    end

endmodule
